// File: rtl/alu_rs.sv
// alu_rs: reservation station feeding the integer ALU.
// Holds dispatched ops until both operands are valid, snoops two CDBs,
// and issues the lowest-index ready entry each cycle.
// Ports: clk_in/rst_n_in/clear_in, disp_* (dispatch), full,
//        cdb0_*/cdb1_* (broadcast), alu_* (registered issue).
module alu_rs #(
  parameter int RS_SIZE = 8,
  parameter int ROB_W   = 4
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             clear_in,
  input  logic             disp_valid,
  input  logic [10:0]      disp_op,
  input  logic             disp_q1_busy,
  input  logic             disp_q2_busy,
  input  logic [ROB_W-1:0] disp_q1,
  input  logic [ROB_W-1:0] disp_q2,
  input  logic [31:0]      disp_v1,
  input  logic [31:0]      disp_v2,
  input  logic [31:0]      disp_pc,
  input  logic [31:0]      disp_imm,
  input  logic [ROB_W-1:0] disp_rob_id,
  output logic             full,
  input  logic             cdb0_valid,
  input  logic             cdb1_valid,
  input  logic [ROB_W-1:0] cdb0_rob_id,
  input  logic [ROB_W-1:0] cdb1_rob_id,
  input  logic [31:0]      cdb0_value,
  input  logic [31:0]      cdb1_value,
  output logic             alu_yes,
  output logic [10:0]      alu_op,
  output logic [31:0]      alu_v1,
  output logic [31:0]      alu_v2,
  output logic [31:0]      alu_pc,
  output logic [31:0]      alu_imm,
  output logic [ROB_W-1:0] alu_rob_id
);

  localparam int IW = $clog2(RS_SIZE);

  typedef struct packed {
    logic [10:0]      op;
    logic             q1b;
    logic [ROB_W-1:0] q1;
    logic [31:0]      v1;
    logic             q2b;
    logic [ROB_W-1:0] q2;
    logic [31:0]      v2;
    logic [31:0]      pc;
    logic [31:0]      imm;
    logic [ROB_W-1:0] rob;
  } ent_t;

  ent_t              ent [RS_SIZE];
  logic [RS_SIZE-1:0] busy;
  logic [RS_SIZE-1:0] rdy;
  logic [IW-1:0]      free_idx;
  logic [IW-1:0]      iss_idx;
  logic               has_rdy;
  ent_t               nd;

  assign full = &busy;

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++)
      rdy[i] = busy[i] & ~ent[i].q1b & ~ent[i].q2b;
  end

  // Descending scan so the lowest index is the last to win.
  always_comb begin
    free_idx = '0;
    iss_idx  = '0;
    has_rdy  = 1'b0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy[i]) free_idx = IW'(i);
      if (rdy[i]) begin
        iss_idx = IW'(i);
        has_rdy = 1'b1;
      end
    end
  end

  // Incoming entry, with same-cycle CDB bypass (cdb0 has priority).
  always_comb begin
    nd.op  = disp_op;
    nd.q1b = disp_q1_busy;
    nd.q1  = disp_q1;
    nd.v1  = disp_v1;
    nd.q2b = disp_q2_busy;
    nd.q2  = disp_q2;
    nd.v2  = disp_v2;
    nd.pc  = disp_pc;
    nd.imm = disp_imm;
    nd.rob = disp_rob_id;
    if (disp_q1_busy) begin
      if (cdb0_valid && cdb0_rob_id == disp_q1) begin
        nd.q1b = 1'b0;
        nd.v1  = cdb0_value;
      end else if (cdb1_valid && cdb1_rob_id == disp_q1) begin
        nd.q1b = 1'b0;
        nd.v1  = cdb1_value;
      end
    end
    if (disp_q2_busy) begin
      if (cdb0_valid && cdb0_rob_id == disp_q2) begin
        nd.q2b = 1'b0;
        nd.v2  = cdb0_value;
      end else if (cdb1_valid && cdb1_rob_id == disp_q2) begin
        nd.q2b = 1'b0;
        nd.v2  = cdb1_value;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      busy <= '0;
      for (int i = 0; i < RS_SIZE; i++) ent[i] <= '0;
      alu_yes    <= 1'b0;
      alu_op     <= '0;
      alu_v1     <= '0;
      alu_v2     <= '0;
      alu_pc     <= '0;
      alu_imm    <= '0;
      alu_rob_id <= '0;
    end else if (clear_in) begin
      busy    <= '0;
      alu_yes <= 1'b0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy[i] && ent[i].q1b) begin
          if (cdb0_valid && cdb0_rob_id == ent[i].q1) begin
            ent[i].q1b <= 1'b0;
            ent[i].v1  <= cdb0_value;
          end else if (cdb1_valid && cdb1_rob_id == ent[i].q1) begin
            ent[i].q1b <= 1'b0;
            ent[i].v1  <= cdb1_value;
          end
        end
        if (busy[i] && ent[i].q2b) begin
          if (cdb0_valid && cdb0_rob_id == ent[i].q2) begin
            ent[i].q2b <= 1'b0;
            ent[i].v2  <= cdb0_value;
          end else if (cdb1_valid && cdb1_rob_id == ent[i].q2) begin
            ent[i].q2b <= 1'b0;
            ent[i].v2  <= cdb1_value;
          end
        end
      end
      alu_yes <= has_rdy;
      if (has_rdy) begin
        busy[iss_idx] <= 1'b0;
        alu_op        <= ent[iss_idx].op;
        alu_v1        <= ent[iss_idx].v1;
        alu_v2        <= ent[iss_idx].v2;
        alu_pc        <= ent[iss_idx].pc;
        alu_imm       <= ent[iss_idx].imm;
        alu_rob_id    <= ent[iss_idx].rob;
      end
      // Free slot is chosen from pre-edge busy bits, so it never
      // collides with the slot being issued this edge.
      if (disp_valid && !full) begin
        busy[free_idx] <= 1'b1;
        ent[free_idx]  <= nd;
      end
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: directed and random checks of alu_rs against a
// slot-level model of dispatch, wakeup, issue, flush and reset.
module tb_alu_rs;

  localparam int N = 8;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        clear_in;
  logic        disp_valid;
  logic [10:0] disp_op;
  logic        disp_q1_busy, disp_q2_busy;
  logic [3:0]  disp_q1, disp_q2, disp_rob_id;
  logic [31:0] disp_v1, disp_v2, disp_pc, disp_imm;
  logic        full;
  logic        cdb0_valid, cdb1_valid;
  logic [3:0]  cdb0_rob_id, cdb1_rob_id;
  logic [31:0] cdb0_value, cdb1_value;
  logic        alu_yes;
  logic [10:0] alu_op;
  logic [31:0] alu_v1, alu_v2, alu_pc, alu_imm;
  logic [3:0]  alu_rob_id;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  alu_rs #(.RS_SIZE(N), .ROB_W(4)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .clear_in(clear_in),
    .disp_valid(disp_valid), .disp_op(disp_op),
    .disp_q1_busy(disp_q1_busy), .disp_q2_busy(disp_q2_busy),
    .disp_q1(disp_q1), .disp_q2(disp_q2),
    .disp_v1(disp_v1), .disp_v2(disp_v2),
    .disp_pc(disp_pc), .disp_imm(disp_imm),
    .disp_rob_id(disp_rob_id), .full(full),
    .cdb0_valid(cdb0_valid), .cdb1_valid(cdb1_valid),
    .cdb0_rob_id(cdb0_rob_id), .cdb1_rob_id(cdb1_rob_id),
    .cdb0_value(cdb0_value), .cdb1_value(cdb1_value),
    .alu_yes(alu_yes), .alu_op(alu_op),
    .alu_v1(alu_v1), .alu_v2(alu_v2),
    .alu_pc(alu_pc), .alu_imm(alu_imm),
    .alu_rob_id(alu_rob_id)
  );

  // Model: one record per slot plus the expected ALU request.
  logic        m_busy [N];
  logic        m_q1b [N], m_q2b [N];
  logic [3:0]  m_q1 [N], m_q2 [N], m_rob [N];
  logic [31:0] m_v1 [N], m_v2 [N], m_pc [N], m_imm [N];
  logic [10:0] m_op [N];
  logic        e_yes;
  logic [10:0] e_op;
  logic [31:0] e_v1, e_v2, e_pc, e_imm;
  logic [3:0]  e_rob;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int n_busy();
    int n = 0;
    for (int i = 0; i < N; i++) if (m_busy[i]) n++;
    return n;
  endfunction

  // Returns {still_pending, value} after looking at the CDBs.
  function automatic logic [32:0] resolve(logic qb, logic [3:0] q,
                                          logic [31:0] v);
    if (qb && cdb0_valid && cdb0_rob_id == q) return {1'b0, cdb0_value};
    if (qb && cdb1_valid && cdb1_rob_id == q) return {1'b0, cdb1_value};
    return {qb, v};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
    e_yes = 0; e_op = '0; e_v1 = '0; e_v2 = '0;
    e_pc = '0; e_imm = '0; e_rob = '0;
  endtask

  task automatic model_edge();
    int iss = -1;
    int fr = -1;
    logic [32:0] r;
    if (!rst_n_in) begin
      model_reset();
      return;
    end
    if (clear_in) begin
      for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
      e_yes = 0;
      return;
    end
    for (int i = 0; i < N; i++) begin
      if (iss < 0 && m_busy[i] && !m_q1b[i] && !m_q2b[i]) iss = i;
      if (fr < 0 && !m_busy[i]) fr = i;
    end
    for (int i = 0; i < N; i++) if (m_busy[i]) begin
      r = resolve(m_q1b[i], m_q1[i], m_v1[i]);
      {m_q1b[i], m_v1[i]} = r;
      r = resolve(m_q2b[i], m_q2[i], m_v2[i]);
      {m_q2b[i], m_v2[i]} = r;
    end
    e_yes = (iss >= 0);
    if (iss >= 0) begin
      e_op = m_op[iss]; e_v1 = m_v1[iss]; e_v2 = m_v2[iss];
      e_pc = m_pc[iss]; e_imm = m_imm[iss]; e_rob = m_rob[iss];
      m_busy[iss] = 1'b0;
    end
    if (disp_valid && fr >= 0) begin
      m_busy[fr] = 1'b1;
      m_op[fr] = disp_op; m_pc[fr] = disp_pc;
      m_imm[fr] = disp_imm; m_rob[fr] = disp_rob_id;
      m_q1[fr] = disp_q1; m_q2[fr] = disp_q2;
      r = resolve(disp_q1_busy, disp_q1, disp_v1);
      {m_q1b[fr], m_v1[fr]} = r;
      r = resolve(disp_q2_busy, disp_q2, disp_v2);
      {m_q2b[fr], m_v2[fr]} = r;
    end
  endtask

  task automatic check_all();
    chk("yes", alu_yes, e_yes);
    chk("op", alu_op, e_op);
    chk("v1", alu_v1, e_v1);
    chk("v2", alu_v2, e_v2);
    chk("pc", alu_pc, e_pc);
    chk("imm", alu_imm, e_imm);
    chk("rob", alu_rob_id, e_rob);
    chk("full", full, n_busy() == N);
  endtask

  task automatic cyc();
    @(posedge clk_in);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle();
    clear_in = 0; disp_valid = 0; disp_op = '0;
    disp_q1_busy = 0; disp_q2_busy = 0;
    disp_q1 = '0; disp_q2 = '0; disp_v1 = '0; disp_v2 = '0;
    disp_pc = '0; disp_imm = '0; disp_rob_id = '0;
    cdb0_valid = 0; cdb1_valid = 0;
    cdb0_rob_id = '0; cdb1_rob_id = '0;
    cdb0_value = '0; cdb1_value = '0;
  endtask

  task automatic disp(input logic [10:0] op, input logic q1b,
                      input logic [3:0] q1, input logic [31:0] v1,
                      input logic q2b, input logic [3:0] q2,
                      input logic [31:0] v2, input logic [31:0] imm,
                      input logic [3:0] rob);
    disp_valid = 1; disp_op = op;
    disp_q1_busy = q1b; disp_q1 = q1; disp_v1 = v1;
    disp_q2_busy = q2b; disp_q2 = q2; disp_v2 = v2;
    disp_imm = imm; disp_rob_id = rob;
    disp_pc = 32'h1000 + {28'd0, rob};
  endtask

  initial begin
    idle();
    model_reset();
    rst_n_in = 0;
    #12;
    chk("rst_yes", alu_yes, 0);
    chk("rst_full", full, 0);
    rst_n_in = 1;
    cyc();

    // ADDI, both operands ready
    disp(11'b000_0010011, 0, 0, 5, 0, 0, 0, 7, 3);
    cyc();
    idle();
    cyc();
    chk("addi_yes", alu_yes, 1);
    chk("addi_v1", alu_v1, 5);
    chk("addi_imm", alu_imm, 7);
    chk("addi_rob", alu_rob_id, 3);
    cyc();
    chk("addi_drop", alu_yes, 0);

    // ADD waiting on rob 2, woken by cdb1
    disp(11'b000_0110011, 1, 2, 0, 0, 0, 10, 0, 4);
    cyc();
    idle();
    cyc();
    cyc();
    chk("wait_yes", alu_yes, 0);
    cdb1_valid = 1; cdb1_rob_id = 2; cdb1_value = 32'h20;
    cyc();
    chk("wake_edge_yes", alu_yes, 0);
    idle();
    cyc();
    chk("wake_yes", alu_yes, 1);
    chk("wake_v1", alu_v1, 32'h20);
    chk("wake_v2", alu_v2, 10);

    // Dispatch bypass from cdb0
    disp(11'h033, 0, 0, 1, 1, 6, 0, 0, 5);
    cdb0_valid = 1; cdb0_rob_id = 6; cdb0_value = 32'hFFFF_FFFF;
    cyc();
    idle();
    cyc();
    chk("byp_yes", alu_yes, 1);
    chk("byp_v2", alu_v2, 32'hFFFF_FFFF);
    chk("byp_rob", alu_rob_id, 5);

    // Fill, overflow, then drain in index order
    for (int i = 0; i < N; i++) begin
      disp(11'h033, 1, 1, 0, 0, 0, i, 0, 4'(i));
      cyc();
    end
    chk("fill_full", full, 1);
    disp(11'h033, 0, 0, 0, 0, 0, 0, 0, 15);
    cyc();
    idle();
    cdb0_valid = 1; cdb0_rob_id = 1; cdb0_value = 32'h100;
    cyc();
    idle();
    for (int k = 0; k < N; k++) begin
      cyc();
      chk("order_yes", alu_yes, 1);
      chk("order_rob", alu_rob_id, k);
      if (k == 0) chk("order_full", full, 0);
    end
    cyc();
    chk("drain_yes", alu_yes, 0);

    // Flush with 4 busy and an issue in flight
    for (int i = 0; i < 5; i++) begin
      disp(11'h013, 1, 9, 0, 0, 0, 0, 0, 4'(i + 8));
      cyc();
    end
    idle();
    cdb0_valid = 1; cdb0_rob_id = 9; cdb0_value = 32'h55;
    cyc();
    idle();
    cyc();
    chk("pre_flush_yes", alu_yes, 1);
    clear_in = 1;
    disp(11'h013, 0, 0, 1, 0, 0, 2, 0, 14);
    cyc();
    chk("flush_yes", alu_yes, 0);
    chk("flush_full", full, 0);
    idle();
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("post_flush_yes", alu_yes, 0);
    end

    // Asynchronous reset between edges
    for (int i = 0; i < 3; i++) begin
      disp(11'h013, 1, 7, 0, 0, 0, 0, 0, 4'(i));
      cyc();
    end
    idle();
    cdb0_valid = 1; cdb0_rob_id = 7; cdb0_value = 32'hABCD;
    cyc();
    idle();
    cyc();
    chk("pre_rst_yes", alu_yes, 1);
    #2 rst_n_in = 0;
    #1;
    model_reset();
    chk("arst_yes", alu_yes, 0);
    chk("arst_v1", alu_v1, 0);
    chk("arst_imm", alu_imm, 0);
    chk("arst_pc", alu_pc, 0);
    chk("arst_full", full, 0);
    cyc();
    #3 rst_n_in = 1;
    cyc();
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("post_rst_yes", alu_yes, 0);
    end

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      idle();
      if (n_busy() < N && ($urandom % 3) != 0) begin
        disp(11'($urandom), 1'($urandom), 4'($urandom_range(0, 3)),
             $urandom, 1'($urandom), 4'($urandom_range(0, 3)),
             $urandom, $urandom, 4'($urandom));
      end
      cdb0_valid = ($urandom % 3) == 0;
      cdb0_rob_id = 4'($urandom_range(0, 3));
      cdb0_value = $urandom;
      cdb1_valid = ($urandom % 3) == 0;
      cdb1_rob_id = 4'($urandom_range(0, 3));
      cdb1_value = (cdb1_rob_id == cdb0_rob_id) ? cdb0_value : $urandom;
      clear_in = ($urandom % 60) == 0;
      cyc();
    end
    idle();
    for (int k = 0; k < 12; k++) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_rs.md
# alu_rs

Reservation station in front of the integer ALU of the out-of-order core. It accepts decoded integer instructions from dispatch, holds them until both source operands are available, and snoops two result broadcast buses (CDBs) for pending operand tags. Each cycle it issues at most one ready entry, oldest-slot-first by index, on the ALU's `yes/op/v1/v2/pc/imm/in_rob_id` request interface.

## Interface
Parameters:
- `RS_SIZE`, 8: number of entries, power of two, ≥2.
- `ROB_W`, 4: ROB id width, matching the ROB range used across the core.

Ports:
- `clk_in` in 1: clock, all state changes on its rising edge.
- `rst_n_in` in 1: reset, asynchronous, active-low.
- `clear_in` in 1: misprediction flush, synchronous.
- `disp_valid` in 1: dispatch request this cycle.
- `disp_op` in 11: op; [6:0] opcode, [9:7] funct3, [10] funct7 bit 5. Passed through unchanged.
- `disp_q1_busy`, `disp_q2_busy` in 1: operand still pending.
- `disp_q1`, `disp_q2` in ROB_W: producer ROB id of the pending operand.
- `disp_v1`, `disp_v2` in 32: operand value, meaningful when the matching busy flag is 0.
- `disp_pc`, `disp_imm` in 32: instruction pc and immediate.
- `disp_rob_id` in ROB_W: destination ROB id.
- `full` out 1: every entry occupied. Combinational from entry state.
- `cdb0_valid`, `cdb1_valid` in 1: broadcast valid. cdb0 is the ALU result, cdb1 is the load/store result.
- `cdb0_rob_id`, `cdb1_rob_id` in ROB_W: broadcast tag.
- `cdb0_value`, `cdb1_value` in 32: broadcast value.
- `alu_yes` out 1: issue valid.
- `alu_op` out 11; `alu_v1`, `alu_v2`, `alu_pc`, `alu_imm` out 32; `alu_rob_id` out ROB_W: issued instruction fields.

## Operation
- Entry state: busy, op, q1_busy, q1, v1, q2_busy, q2, v2, pc, imm, rob_id.
- **Dispatch.** When `disp_valid` is 1, `full` is 0 and `clear_in` is 0, the request is written into the lowest-index non-busy entry.
  - Dispatch while `full` is 1 is ignored and lost. Dispatch logic must not assert it.
- **Dispatch bypass.** If `disp_qX_busy` is 1 and a valid CDB in the same cycle carries tag `disp_qX`, the entry stores that CDB value with qX_busy = 0.
- **Wakeup.** For every busy entry with qX_busy = 1, a valid CDB whose tag equals qX writes vX and clears qX_busy at the edge.
  - Both CDBs may match different operands of the same entry in the same cycle, and both updates apply.
  - If both CDBs carry the same tag, cdb0 wins; the values are identical by construction.
- **Ready.** An entry is ready when busy = 1, q1_busy = 0 and q2_busy = 0, using pre-edge registered state.
  - An operand woken at edge N makes its entry eligible for selection at edge N+1. There is no same-cycle wakeup-to-issue.
- **Issue.** At each edge, the lowest-index ready entry is copied into the `alu_*` registers, `alu_yes` is set to 1, and that entry's busy bit is cleared.
  - With no ready entry, `alu_yes` becomes 0 and the other `alu_*` registers hold their values.
- **Same-entry free and refill.** An entry freed by issue at edge N is not reused by a dispatch at edge N, because allocation uses the pre-edge busy bits. It is reusable from edge N+1.
- **Flush.** `clear_in` = 1 at an edge clears every busy bit and `alu_yes`, and overrides any dispatch, wakeup or issue in that cycle.
- **Reset.** While `rst_n_in` = 0: all busy bits = 0, `alu_yes` = 0, `alu_op`/`alu_v1`/`alu_v2`/`alu_pc`/`alu_imm`/`alu_rob_id` = 0, `full` = 0. The effect is immediate and independent of the clock.

## Timing
- Dispatch with both operands ready at edge N: `alu_yes` = 1 during cycle N+1 (after edge N+1); the ALU latches it at edge N+2.
  - Minimum dispatch-to-ALU-request latency is one cycle of RS residency.
- Dispatch with a pending operand broadcast at edge M ≥ N: issued at edge max(N,M)+1.
- Throughput: one issue per cycle. Back-to-back issues hold `alu_yes` high continuously.
- `full` reflects busy bits after the most recent edge. The dispatcher samples it in the same cycle it drives `disp_valid`.

## Test plan
- **Reset and basic issue.** Release reset; dispatch ADDI (op = 0010011, funct3 = 000), v1 = 5, imm = 7, rob = 3, no pending operands.
  - `alu_yes` = 1 exactly one cycle after the dispatch edge with v1 = 5, imm = 7, rob_id = 3. It drops to 0 the next cycle.
- **Pending operand and wakeup.** Dispatch ADD with q1 = 2 pending, v2 = 10; three cycles later drive cdb1 valid with tag 2, value 0x20.
  - Issue occurs the edge after the broadcast, carrying v1 = 0x20, v2 = 10.
- **Dispatch bypass.** Dispatch with q2 = 6 pending while cdb0 broadcasts tag 6, value 0xFFFF_FFFF in the same cycle.
  - Entry issues next edge with v2 = 0xFFFF_FFFF; no further broadcast is needed.
- **Full and order.** Fill all 8 entries, each with q1 = 1 pending.
  - `full` = 1; a 9th dispatch is ignored.
  - Broadcast tag 1: entries issue in index order 0..7 on consecutive cycles, and `full` drops after the first issue.
- **Flush.** With 4 entries busy and `alu_yes` = 1, assert `clear_in` together with `disp_valid`.
  - Next cycle `alu_yes` = 0 and `full` = 0; no entry issues afterwards, including the dispatch from the flush cycle.
- **Asynchronous reset mid-operation.** Drop `rst_n_in` between edges while entries are busy.
  - `alu_yes` and all `alu_*` fields go to 0 immediately; after release, no stale entry issues.
